// File: rtl/clk125_pll_rst_seq.sv
// clk125_pll_rst_seq: PLL reset/lock sequencer with ordered domain reset release; CLK125_PLL_SEQ_STATUS_EN enables lock_loss_cnt
module clk125_pll_rst_seq #(
    parameter int NUM_DOMAINS      = 4,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 125000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int DOMAIN_GAP_CYC   = 8,
    parameter int MAX_RETRY        = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked_async,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fail,
    output logic [2:0]             retry_cnt,
    output logic [7:0]             lock_loss_cnt
);
    localparam int REL_CYC = (NUM_DOMAINS - 1) * DOMAIN_GAP_CYC;
    localparam int M0 = PLL_RST_CYC > LOCK_TIMEOUT_CYC ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int M1 = LOCK_STABLE_CYC > REL_CYC ? LOCK_STABLE_CYC : REL_CYC;
    localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);

    typedef enum logic [2:0] {S_RESET, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_FAIL} state_t;

    state_t                 state, nx_state;
    logic [CW-1:0]          cnt, nx_cnt;
    logic [1:0]             sync;
    logic                   locked_s, nx_pll_rst, nx_ready, nx_fail;
    logic [NUM_DOMAINS-1:0] nx_dom;
    logic [2:0]             nx_retry;

    assign locked_s = sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync         <= '0;
            state        <= S_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            fail         <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            sync         <= {sync[0], pll_locked_async};
            state        <= nx_state;
            cnt          <= nx_cnt;
            pll_rst      <= nx_pll_rst;
            domain_rst_n <= nx_dom;
            ready        <= nx_ready;
            fail         <= nx_fail;
            retry_cnt    <= nx_retry;
        end
    end

    always_comb begin
        nx_state   = state;
        nx_cnt     = cnt + 1'b1;
        nx_pll_rst = 1'b0;
        nx_dom     = '0;
        nx_ready   = 1'b0;
        nx_fail    = 1'b0;
        nx_retry   = retry_cnt;
        case (state)
            S_RESET: begin
                nx_pll_rst = 1'b1;
                if (cnt == CW'(PLL_RST_CYC - 1)) begin
                    nx_state   = S_WAIT_LOCK;
                    nx_cnt     = '0;
                    nx_pll_rst = 1'b0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    nx_state  = LOCK_STABLE_CYC == 1 ? S_RELEASE : S_STABLE;
                    nx_cnt    = CW'(LOCK_STABLE_CYC == 1 ? 0 : 1);
                    nx_dom[0] = LOCK_STABLE_CYC == 1;
                end else if (cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                    nx_retry   = retry_cnt + 3'd1;
                    nx_fail    = nx_retry == 3'(MAX_RETRY);
                    nx_state   = nx_fail ? S_FAIL : S_RESET;
                    nx_cnt     = '0;
                    nx_pll_rst = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    nx_state = S_WAIT_LOCK;
                    nx_cnt   = '0;
                end else if (cnt == CW'(LOCK_STABLE_CYC - 1)) begin
                    nx_state  = S_RELEASE;
                    nx_cnt    = '0;
                    nx_dom[0] = 1'b1;
                end
            end
            S_RELEASE: begin
                if (domain_rst_n[NUM_DOMAINS-1]) begin
                    nx_state = S_RUN;
                    nx_cnt   = '0;
                    nx_dom   = '1;
                    nx_ready = 1'b1;
                    nx_retry = '0;
                end else begin
                    for (int i = 0; i < NUM_DOMAINS; i++)
                        nx_dom[i] = int'(cnt) + 1 >= i * DOMAIN_GAP_CYC;
                end
            end
            S_RUN: begin
                nx_cnt   = '0;
                nx_dom   = '1;
                nx_ready = 1'b1;
            end
            default: begin
                nx_cnt     = '0;
                nx_pll_rst = 1'b1;
                nx_fail    = 1'b1;
            end
        endcase
        if ((state == S_RELEASE || state == S_RUN) && !locked_s) begin
            nx_state   = S_RESET;
            nx_cnt     = '0;
            nx_pll_rst = 1'b1;
            nx_dom     = '0;
            nx_ready   = 1'b0;
            nx_retry   = retry_cnt;
        end
        if (relock_req) begin
            nx_state   = S_RESET;
            nx_cnt     = '0;
            nx_pll_rst = 1'b1;
            nx_dom     = '0;
            nx_ready   = 1'b0;
            nx_fail    = 1'b0;
            nx_retry   = '0;
        end
    end

`ifdef CLK125_PLL_SEQ_STATUS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            lock_loss_cnt <= '0;
        else if (!relock_req && !locked_s && (state == S_RELEASE || state == S_RUN) && lock_loss_cnt != 8'hff)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`else
    assign lock_loss_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_clk125_pll_rst_seq.sv
// tb_clk125_pll_rst_seq: directed scenarios plus random lock/relock/reset traffic against a phase-level reference model
module tb_clk125_pll_rst_seq;
    localparam int N = 4, PRC = 4, TO = 32, STB = 8, GAP = 2, MR = 2;
`ifdef CLK125_PLL_SEQ_STATUS_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, lk = 1'b0, relock = 1'b0;
    logic pll_rst, ready, fail;
    logic [N-1:0] dom;
    logic [2:0] retry;
    logic [7:0] loss;
    int total = 0, bad = 0;
    int e = -1, c = 0;
    int first [7];

    typedef enum {M_RST, M_WAIT, M_STB, M_REL, M_RUN, M_FAIL} ph_t;
    ph_t ph = M_RST;
    int el = 0, run_len = 0, rel = 0, m_retry = 0, m_loss = 0;
    bit m_fail = 1'b0;
    logic s1 = 1'b0, s2 = 1'b0;

    clk125_pll_rst_seq #(
        .NUM_DOMAINS(N), .PLL_RST_CYC(PRC), .LOCK_TIMEOUT_CYC(TO),
        .LOCK_STABLE_CYC(STB), .DOMAIN_GAP_CYC(GAP), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked_async(lk), .relock_req(relock),
        .pll_rst(pll_rst), .domain_rst_n(dom), .ready(ready), .fail(fail),
        .retry_cnt(retry), .lock_loss_cnt(loss)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic ls;
        ls = s2;
        if (!rst_n) begin
            ph = M_RST; el = 0; m_retry = 0; m_fail = 1'b0; m_loss = 0; s1 = 1'b0; s2 = 1'b0;
            return;
        end
        s2 = s1;
        s1 = lk;
        if (relock) begin
            ph = M_RST; el = 0; m_retry = 0; m_fail = 1'b0;
            return;
        end
        case (ph)
            M_RST: begin
                el++;
                if (el == PRC) begin ph = M_WAIT; el = 0; end
            end
            M_WAIT, M_STB: begin
                if (ls) begin
                    run_len = (ph == M_WAIT) ? 1 : run_len + 1;
                    ph = (run_len == STB) ? M_REL : M_STB;
                    rel = 0;
                end else if (ph == M_STB) begin
                    ph = M_WAIT; el = 0;
                end else begin
                    el++;
                    if (el == TO) begin
                        m_retry++; el = 0;
                        m_fail = (m_retry == MR);
                        ph = m_fail ? M_FAIL : M_RST;
                    end
                end
            end
            M_REL, M_RUN: begin
                if (!ls) begin
                    ph = M_RST; el = 0;
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                end else if (ph == M_REL) begin
                    if (rel >= (N - 1) * GAP) begin ph = M_RUN; m_retry = 0; end
                    else rel++;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [N-1:0] exp_dom();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = (ph == M_RUN) || (ph == M_REL && i * GAP <= rel);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        e++;
        c = e + 1;
        @(negedge clk);
        chk("pll_rst", pll_rst, ph == M_RST || ph == M_FAIL);
        chk("domain_rst_n", dom, exp_dom());
        chk("ready", ready, ph == M_RUN);
        chk("fail", fail, m_fail);
        chk("retry_cnt", retry, m_retry);
        chk("lock_loss_cnt", loss, EN ? m_loss : 0);
        chk("monotonic", dom & (dom + 1'b1), 0);
        if (first[0] < 0 && !pll_rst) first[0] = c;
        for (int i = 0; i < N; i++) if (first[i+1] < 0 && dom[i]) first[i+1] = c;
        if (first[5] < 0 && ready) first[5] = c;
        if (first[6] < 0 && fail) first[6] = c;
    endtask

    task automatic restart();
        rst_n = 1'b1;
        e = -1;
        foreach (first[i]) first[i] = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; lk = 1'b0; relock = 1'b0;
        repeat (3) tick();
        restart();
    endtask

    task automatic nominal(input string tag);
        repeat (30) begin lk = (e + 1 >= 10); tick(); end
        chk({tag, "_pll_fall"}, first[0], 4);
        for (int i = 0; i < N; i++) chk({tag, "_dom_rise"}, first[i+1], 20 + GAP * i);
        chk({tag, "_ready_rise"}, first[5], 27);
        chk({tag, "_retry"}, retry, 0);
    endtask

    initial begin
        foreach (first[i]) first[i] = -1;
        do_reset();
        nominal("s1");
        lk = 1'b0; tick();
        lk = 1'b1; tick();
        chk("s4_ready_hold", ready, 1);
        tick();
        chk("s4_ready_drop", ready, 0);
        chk("s4_dom_drop", dom, 0);
        chk("s4_loss", loss, EN ? 1 : 0);
        for (int i = 0; i < 60 && !ready; i++) tick();
        chk("s4_rerun_ready", ready, 1);

        do_reset();
        repeat (40) begin
            lk = (e + 1 >= 10 && e + 1 <= 13) || e + 1 >= 15;
            tick();
        end
        for (int i = 0; i < N; i++) chk("s2_dom_rise", first[i+1], 25 + GAP * i);
        chk("s2_ready_rise", first[5], 32);

        do_reset();
        repeat (36) tick();
        chk("s3_retry1", retry, 1);
        chk("s3_repulse_start", pll_rst, 1);
        repeat (3) tick();
        chk("s3_repulse_end", pll_rst, 1);
        tick();
        chk("s3_repulse_done", pll_rst, 0);
        for (int i = 0; i < 80 && !fail; i++) tick();
        chk("s3_fail_cycle", first[6], 72);
        chk("s3_fail_pll", pll_rst, 1);
        chk("s3_fail_dom", dom, 0);

        relock = 1'b1; tick(); relock = 1'b0;
        chk("s5_fail_dom", dom, 0);
        chk("s5_fail_clr", fail, 0);
        chk("s5_fail_retry", retry, 0);
        chk("s5_fail_pll", pll_rst, 1);
        repeat (3) tick();
        chk("s5_pll_hold", pll_rst, 1);
        tick();
        chk("s5_pll_drop", pll_rst, 0);
        lk = 1'b1;
        for (int i = 0; i < 60 && !dom[1]; i++) tick();
        chk("s5_mid_release", dom, 4'b0011);
        relock = 1'b1; tick(); relock = 1'b0;
        chk("s5_rel_dom", dom, 0);
        chk("s5_rel_pll", pll_rst, 1);
        chk("s5_rel_retry", retry, 0);
        chk("s5_rel_fail", fail, 0);

        do_reset();
        repeat (16) begin lk = (e + 1 >= 10); tick(); end
        rst_n = 1'b0; lk = 1'b0; tick();
        chk("s6_pll", pll_rst, 1);
        chk("s6_dom", dom, 0);
        chk("s6_ready", ready, 0);
        chk("s6_retry", retry, 0);
        restart();
        nominal("s6");

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < (lk ? 1 : 4)) lk = ~lk;
            relock = ($urandom_range(0, 399) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
